// File: rtl/player_motion_controller_4dir_if.sv
// Player motion controller bus: button/bounds/gravity/floor inputs and position/state outputs.
// Latency: none, wires only.
// Backpressure: none; all signals are level signals that are sampled every tick.
//
// master : the switch/debounce and playfield side that drives buttons, bounds, gravity and floor
// slave  : the motion controller that consumes those and drives position, size and motion state
interface player_motion_controller_4dir_if #(
   parameter int POS_W = 10
) ();
   logic             btn_up;
   logic             btn_down;
   logic             btn_left;
   logic             btn_right;
   logic [POS_W-1:0] bound_x0;
   logic [POS_W-1:0] bound_y0;
   logic [POS_W-1:0] bound_x1;
   logic [POS_W-1:0] bound_y1;
   logic [2:0]       gravity_direction;
   logic             floor_valid;
   logic [POS_W-1:0] floor_pos;
   logic [POS_W-1:0] player_pos_x;
   logic [POS_W-1:0] player_pos_y;
   logic [POS_W-1:0] player_w;
   logic [POS_W-1:0] player_h;
   logic [1:0]       motion_state;
   logic             on_ground;

   modport master (
      output btn_up, btn_down, btn_left, btn_right,
      output bound_x0, bound_y0, bound_x1, bound_y1,
      output gravity_direction, floor_valid, floor_pos,
      input  player_pos_x, player_pos_y, player_w, player_h,
      input  motion_state, on_ground
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right,
      input  bound_x0, bound_y0, bound_x1, bound_y1,
      input  gravity_direction, floor_valid, floor_pos,
      output player_pos_x, player_pos_y, player_w, player_h,
      output motion_state, on_ground
   );
endinterface

// File: rtl/player_motion_controller_4dir.sv
// Fixed-point player motion controller with FREE/GROUND/JUMP/FALL state machine and 4-way gravity.
// Latency: one tick; inputs sampled at edge N are reflected in the registered outputs after edge N.
// Backpressure: none; the controller advances unconditionally every tick.
//
// Ports:
//   clk_player_control : tick clock
//   reset              : synchronous, active-high; restores START_X/START_Y, FALL, zero velocity
//   bus (slave)        : buttons, play box, gravity direction, optional floor collider in;
//                        integer pixel position, size, motion_state and on_ground out
module player_motion_controller_4dir #(
   parameter int POS_W      = 10,
   parameter int FRAC_BITS  = 4,
   parameter int START_X    = 320,
   parameter int START_Y    = 240,
   parameter int PLAYER_W   = 30,
   parameter int PLAYER_H   = 30,
   parameter int MOVE_SPEED = 15,
   parameter int JUMP_SPEED = 22,
   parameter int GRAVITY    = 8,
   parameter int MAX_FALL   = 560,
   parameter int JUMP_H     = 80
) (
   input logic                      clk_player_control,
   input logic                      reset,
   player_motion_controller_4dir_if.slave bus
);

   localparam int HW = POS_W + FRAC_BITS;
   // Two guard bits so sums, differences and negative apex values never wrap.
   localparam int EW = HW + 2;

   typedef logic signed [EW-1:0] ext_t;

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_GROUND = 2'd1,
      ST_JUMP   = 2'd2,
      ST_FALL   = 2'd3
   } state_e;

   localparam ext_t ZERO_E   = ext_t'(0);
   localparam ext_t MOVE_E   = ext_t'(MOVE_SPEED);
   localparam ext_t JUMP_E   = ext_t'(JUMP_SPEED);
   localparam ext_t GRAV_E   = ext_t'(GRAVITY);
   localparam ext_t MAXF_E   = ext_t'(MAX_FALL);
   localparam ext_t JUMPH_E  = ext_t'(JUMP_H * (1 << FRAC_BITS));
   localparam ext_t PW_E     = ext_t'(PLAYER_W);
   localparam ext_t PH_E     = ext_t'(PLAYER_H);

   function automatic ext_t px2ext(input logic [POS_W-1:0] p);
      return ext_t'({{(EW-POS_W){1'b0}}, p});
   endfunction

   state_e          state_q, state_d;
   logic [HW-1:0]   hx_q, hx_d;
   logic [HW-1:0]   hy_q, hy_d;
   logic [HW-1:0]   vel_q, vel_d;
   ext_t            apex_q, apex_d;
   logic [2:0]      dir_q, dir_d;

   logic [2:0]      dir_n;
   logic            dir_chg;
   logic            axis_y;
   logic            toward_pos;
   logic            jump_btn;
   logic            hit;
   logic            reached;
   logic            land;
   state_e          st_cur;
   ext_t            x_e, y_e, g_pos;
   ext_t            x_lo, x_hi, y_lo, y_hi;
   ext_t            near_px, flr_px, lim_px, lim, wall, size_e;
   ext_t            vel_cur, apex_cur, vel_sum, vel_e;
   ext_t            lr_step, ud_step;
   ext_t            g_step, g_new, x_new, y_new, x_cl, y_cl;

   always_ff @(posedge clk_player_control) begin
      if (reset) begin
         state_q <= ST_FALL;
         hx_q    <= HW'(START_X * (1 << FRAC_BITS));
         hy_q    <= HW'(START_Y * (1 << FRAC_BITS));
         vel_q   <= '0;
         apex_q  <= ZERO_E;
         dir_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         hx_q    <= hx_d;
         hy_q    <= hy_d;
         vel_q   <= vel_d;
         apex_q  <= apex_d;
         dir_q   <= dir_d;
      end
   end

   always_comb begin
      // Codes 5..7 decode as "no gravity".
      dir_n = 3'd0;
      if (bus.gravity_direction inside {3'd1, 3'd2, 3'd3, 3'd4}) dir_n = bus.gravity_direction;
      dir_chg    = (dir_n != dir_q);
      axis_y     = (dir_n == 3'd1) || (dir_n == 3'd3);
      // Gravity pulls toward increasing coordinates for down and right.
      toward_pos = (dir_n == 3'd2) || (dir_n == 3'd3);

      jump_btn = 1'b0;
      case (dir_n)
         3'd1:    jump_btn = bus.btn_down;
         3'd2:    jump_btn = bus.btn_left;
         3'd3:    jump_btn = bus.btn_up;
         3'd4:    jump_btn = bus.btn_right;
         default: jump_btn = 1'b0;
      endcase

      x_e   = ext_t'({2'b00, hx_q});
      y_e   = ext_t'({2'b00, hy_q});
      g_pos = axis_y ? y_e : x_e;

      x_lo = px2ext(bus.bound_x0) <<< FRAC_BITS;
      y_lo = px2ext(bus.bound_y0) <<< FRAC_BITS;
      x_hi = (px2ext(bus.bound_x1) - PW_E) <<< FRAC_BITS;
      y_hi = (px2ext(bus.bound_y1) - PH_E) <<< FRAC_BITS;

      // Landing limit: the nearer of the box edge and the collider on the gravity side.
      size_e  = axis_y ? PH_E : PW_E;
      near_px = axis_y ? (toward_pos ? px2ext(bus.bound_y1) : px2ext(bus.bound_y0))
                       : (toward_pos ? px2ext(bus.bound_x1) : px2ext(bus.bound_x0));
      flr_px  = px2ext(bus.floor_pos);
      lim_px  = near_px;
      if (bus.floor_valid) begin
         if (toward_pos ? (flr_px < near_px) : (flr_px > near_px)) lim_px = flr_px;
      end
      lim  = toward_pos ? ((lim_px - size_e) <<< FRAC_BITS) : (lim_px <<< FRAC_BITS);
      // Wall on the anti-gravity side that stops a jump.
      wall = axis_y ? (toward_pos ? y_lo : y_hi) : (toward_pos ? x_lo : x_hi);

      // A direction change resets the motion context in the same tick it is seen.
      st_cur   = (dir_n == 3'd0) ? ST_FREE : (dir_chg ? ST_FALL : state_q);
      vel_cur  = dir_chg ? ZERO_E : ext_t'({2'b00, vel_q});
      apex_cur = dir_chg ? ZERO_E : apex_q;

      lr_step = ZERO_E;
      if (bus.btn_right && !bus.btn_left) lr_step = MOVE_E;
      if (bus.btn_left && !bus.btn_right) lr_step = -MOVE_E;
      ud_step = ZERO_E;
      if (bus.btn_down && !bus.btn_up) ud_step = MOVE_E;
      if (bus.btn_up && !bus.btn_down) ud_step = -MOVE_E;

      state_d = st_cur;
      vel_e   = vel_cur;
      apex_d  = apex_cur;
      vel_sum = ZERO_E;
      g_step  = g_pos;
      g_new   = g_pos;
      x_new   = x_e;
      y_new   = y_e;
      hit     = 1'b0;
      reached = 1'b0;
      land    = 1'b0;

      case (st_cur)
         ST_FREE: begin
            x_new = x_e + lr_step;
            y_new = y_e + ud_step;
         end
         ST_GROUND: begin
            vel_e = ZERO_E;
            if (jump_btn) begin
               state_d = ST_JUMP;
               apex_d  = toward_pos ? (g_pos - JUMPH_E) : (g_pos + JUMPH_E);
            end else if (g_pos != lim) begin
               state_d = ST_FALL;
            end
         end
         ST_JUMP: begin
            g_step  = toward_pos ? (g_pos - JUMP_E) : (g_pos + JUMP_E);
            hit     = toward_pos ? (g_step < wall) : (g_step > wall);
            if (hit) g_step = wall;
            reached = toward_pos ? (g_step <= apex_cur) : (g_step >= apex_cur);
            g_new   = g_step;
            if (!jump_btn || reached || hit) begin
               state_d = ST_FALL;
               vel_e   = ZERO_E;
            end
         end
         default: begin
            vel_sum = vel_cur + GRAV_E;
            vel_e   = (vel_sum > MAXF_E) ? MAXF_E : vel_sum;
            g_step  = toward_pos ? (g_pos + vel_e) : (g_pos - vel_e);
            land    = toward_pos ? (g_step >= lim) : (g_step <= lim);
            if (land) begin
               g_step  = lim;
               vel_e   = ZERO_E;
               state_d = ST_GROUND;
            end
            g_new = g_step;
         end
      endcase

      if (st_cur != ST_FREE) begin
         if (axis_y) begin
            y_new = g_new;
            x_new = x_e + lr_step;
         end else begin
            x_new = g_new;
            y_new = y_e + ud_step;
         end
      end

      // Box clamp; the low edge is applied last so an undersized box snaps to x0/y0.
      x_cl = x_new;
      if (x_cl > x_hi) x_cl = x_hi;
      if (x_cl < x_lo) x_cl = x_lo;
      y_cl = y_new;
      if (y_cl > y_hi) y_cl = y_hi;
      if (y_cl < y_lo) y_cl = y_lo;

      hx_d  = HW'(x_cl);
      hy_d  = HW'(y_cl);
      vel_d = HW'(vel_e);
      dir_d = dir_n;
   end

   assign bus.player_pos_x = POS_W'(hx_q >> FRAC_BITS);
   assign bus.player_pos_y = POS_W'(hy_q >> FRAC_BITS);
   assign bus.player_w     = POS_W'(PLAYER_W);
   assign bus.player_h     = POS_W'(PLAYER_H);
   assign bus.motion_state = state_q;
   assign bus.on_ground    = (state_q == ST_GROUND);

endmodule
